br_resolve_queue: RTL
=====================

BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DEPTH, default 4, update-queue entry count; SHALL be a power of two and at least 2.
REQ-003 clk  in  1  clock, all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 ex_valid  in  1  resolved-branch candidate from ex0.
REQ-006 ex_ready  out  1  queue can accept; equals not-full.
REQ-007 ex_pc  in  32  instruction PC.
REQ-008 ex_btype  in  2  branch type: 00 not branch, 01 unconditional, 10 PC-relative, 11 indirect.
REQ-009 ex_taken  in  1  actual direction.
REQ-010 ex_tpc  in  32  actual target.
REQ-011 ex_pred_taken  in  2  prediction carried down the pipe; nonzero means predicted taken.
REQ-012 ex_pred_pc  in  32  predicted next PC carried down the pipe.
REQ-013 redirect_valid  out  1  one-cycle mispredict flush pulse to fetch.
REQ-014 redirect_pc  out  32  correct next PC for the flush.
REQ-015 upd_en  in  1  predictor may consume an update this cycle.
REQ-016 fact_pc, fact_tpc  out  32 each  head-entry PC and target.
REQ-017 fact_taken, predict_dir_fail, predict_add_fail  out  1 each  head-entry training flags.
REQ-018 stat_br, stat_miss  out  32 each  resolved-branch and mispredict counters.

Function
REQ-019 Accept SHALL be ex_valid && ex_ready && ex_btype!=00; btype 00 SHALL be dropped, with no enqueue, redirect or count.
REQ-020 pt SHALL be (ex_pred_taken!=00); dir_fail SHALL be (pt != ex_taken).
REQ-021 add_fail SHALL be ex_taken && pt && (ex_pred_pc != ex_tpc).
REQ-022 On accept with dir_fail or add_fail, redirect_valid SHALL assert for exactly one cycle, on the cycle after accept.
REQ-023 redirect_pc SHALL be ex_tpc if ex_taken, else ex_pc+4, mod 2^32, registered with redirect_valid.
REQ-024 On accept, the entry {ex_pc, ex_tpc, ex_taken, dir_fail, add_fail} SHALL be written at the write pointer.
REQ-025 Pointers SHALL be log2(DEPTH) bits and wrap naturally; the occupancy count SHALL be log2(DEPTH)+1 bits.
REQ-026 The queue SHALL have no bypass: an entry accepted into an empty queue appears on the fact_* outputs the next cycle.
REQ-027 fact_pc and fact_tpc SHALL always show the head-entry fields.
REQ-028 The three flags SHALL show the head-entry fields when non-empty and SHALL be forced to 0 when empty, because the predictor treats fact_taken as a write enable.
REQ-029 Pop SHALL be upd_en && non-empty; the head advances one entry per pop.
REQ-030 Simultaneous push and pop SHALL keep the count unchanged, including at occupancy 1.
REQ-031 At full, ex_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-032 stat_br SHALL increment on each accept; stat_miss SHALL increment on each accept with dir_fail||add_fail.
REQ-033 Both counters SHALL saturate at 0xFFFFFFFF.

Reset
REQ-034 On rst: pointers, count, redirect_valid and counters SHALL be 0; redirect_pc SHALL be 0.
REQ-035 On rst, the flag outputs SHALL be 0, entry storage need not be cleared, and ex_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-036 rst asserted mid-operation SHALL discard all queued entries and any pending redirect immediately, without waiting for a clock edge.

Verification
REQ-037 Correct prediction: pc=0x1C000010, btype=10, taken=1, tpc=0x1C000040, pred_taken=01, pred_pc=0x1C000040, upd_en=1 -> no redirect; next cycle fact_taken=1 and both fails 0; stat_br=1, stat_miss=0.
REQ-038 Direction miss: pc=0x1C000020, taken=0, pred_taken=10 -> redirect_valid pulse with redirect_pc=0x1C000024; head entry predict_dir_fail=1, fact_taken=0.
REQ-039 Address miss: btype=11, taken=1, tpc=0x1C000100, pred_taken=01, pred_pc=0x1C000200 -> redirect_pc=0x1C000100; predict_add_fail=1, dir_fail=0.
REQ-040 Backpressure: upd_en=0, five accepts attempted -> ex_ready=0 after the 4th accept and the 5th is held; then upd_en=1 -> four entries drain in order, one per cycle, and flags read 0 after the last pop.
REQ-041 Filter and wrap: btype=00 with ex_valid=1 -> no change; 10 accept/pop pairs across pointer wrap -> FIFO order preserved; rst pulse with 3 entries queued -> flags immediately 0 and count 0.

Source files
------------

// File: rtl/br_resolve_queue.sv
// br_resolve_queue: resolved-branch update queue with mispredict redirect.
// Ports: clk/rst; ex_* candidate in, ex_ready out; redirect_* flush out;
//        upd_en pop in; fact_*/predict_*_fail head entry out; stat_* counters.
module br_resolve_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [1:0]  ex_btype,
    input  logic        ex_taken,
    input  logic [31:0] ex_tpc,
    input  logic [1:0]  ex_pred_taken,
    input  logic [31:0] ex_pred_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        upd_en,
    output logic [31:0] fact_pc,
    output logic [31:0] fact_tpc,
    output logic        fact_taken,
    output logic        predict_dir_fail,
    output logic        predict_add_fail,
    output logic [31:0] stat_br,
    output logic [31:0] stat_miss
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tpc;
        logic        taken;
        logic        dir_fail;
        logic        add_fail;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic pt;
    logic dir_fail;
    logic add_fail;
    logic miss;
    logic empty;
    logic full;
    logic accept;
    logic pop;

    assign pt       = (ex_pred_taken != 2'b00);
    assign dir_fail = (pt != ex_taken);
    assign add_fail = ex_taken && pt && (ex_pred_pc != ex_tpc);
    assign miss     = dir_fail || add_fail;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // Ready ignores a same-cycle pop so it never depends on upd_en.
    assign ex_ready = !full;
    assign accept   = ex_valid && ex_ready && (ex_btype != 2'b00);
    assign pop      = upd_en && !empty;

    assign head     = mem[rd_ptr];
    assign fact_pc  = head.pc;
    assign fact_tpc = head.tpc;
    // Flags gate predictor writes, so stale storage must not leak out.
    assign fact_taken       = head.taken    && !empty;
    assign predict_dir_fail = head.dir_fail && !empty;
    assign predict_add_fail = head.add_fail && !empty;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{pc: ex_pc, tpc: ex_tpc, taken: ex_taken,
                             dir_fail: dir_fail, add_fail: add_fail};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stat_br        <= '0;
            stat_miss      <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            redirect_valid <= accept && miss;
            if (accept && miss) begin
                redirect_pc <= ex_taken ? ex_tpc : ex_pc + 32'd4;
            end
            if (accept && stat_br != 32'hFFFF_FFFF) begin
                stat_br <= stat_br + 32'd1;
            end
            if (accept && miss && stat_miss != 32'hFFFF_FFFF) begin
                stat_miss <= stat_miss + 32'd1;
            end
        end
    end
endmodule
